// File: rtl/cfg_stream_loader.sv
// cfg_stream_loader: serial configuration bitstream deserialiser with sync hunt and additive checksum
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   cfg_si, cfg_en : serial data (MSB-first per word) and its bit-valid qualifier
//   cfg_restart    : synchronous return to HUNT; loaded words are kept
//   cfg_words      : flattened word array, word i at [32i+31:32i]
//   cfg_done, cfg_error, fabric_en, cfg_busy : load status; fabric_en mirrors cfg_done
module cfg_stream_loader #(
  parameter int NUM_WORDS = 56,
  parameter logic [31:0] SYNC_WORD = 32'hA5C3_0F1E,
  parameter int WORD_W = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        cfg_si,
  input  logic                        cfg_en,
  input  logic                        cfg_restart,
  output logic [NUM_WORDS*WORD_W-1:0] cfg_words,
  output logic                        cfg_done,
  output logic                        cfg_error,
  output logic                        fabric_en,
  output logic                        cfg_busy
);
  localparam int IW = $clog2(NUM_WORDS + 1);
  typedef enum logic [2:0] {HUNT, LOAD, CHECK, DONE, ERROR} state_t;
  state_t state;
  logic [WORD_W-1:0] sr, acc;
  logic [4:0] bit_cnt;
  logic [IW-1:0] idx;
  logic [WORD_W-1:0] nxt;
  assign nxt = {sr[WORD_W-2:0], cfg_si};
  assign fabric_en = cfg_done;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= HUNT;
      sr <= '0;
      acc <= '0;
      bit_cnt <= '0;
      idx <= '0;
      cfg_words <= '0;
      cfg_done <= 1'b0;
      cfg_error <= 1'b0;
      cfg_busy <= 1'b0;
    end else if (cfg_restart) begin
      state <= HUNT;
      sr <= '0;
      acc <= '0;
      bit_cnt <= '0;
      idx <= '0;
      cfg_done <= 1'b0;
      cfg_error <= 1'b0;
      cfg_busy <= 1'b0;
    end else if (cfg_en) begin
      sr <= nxt;
      case (state)
        HUNT:
          if (nxt == SYNC_WORD) begin
            state <= LOAD;
            bit_cnt <= '0;
            idx <= '0;
            acc <= '0;
            cfg_done <= 1'b0;
            cfg_error <= 1'b0;
            cfg_busy <= 1'b1;
          end
        LOAD: begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            cfg_words[idx*WORD_W +: WORD_W] <= nxt;
            acc <= acc + nxt;
            idx <= idx + IW'(1);
            if (idx == IW'(NUM_WORDS - 1)) state <= CHECK;
          end
        end
        CHECK: begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            state <= (nxt == acc) ? DONE : ERROR;
            cfg_done <= (nxt == acc);
            cfg_error <= (nxt != acc);
            cfg_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: doc/cfg_stream_loader.md
Name: cfg_stream_loader

Overview:
- Receiving end of the fabric configuration path: accepts a serial configuration bitstream and deserialises it into the configuration word array that drives LUT `mem` and switch-box `configure` fields of the 8-bit shift-register fabric.
- Word layout per tile t (7 words, base 7×(7−t)):
  - LUT1 uses {w[b+1][0], w[b]}.
  - LUT2 uses {w[b+3][0], w[b+2]}.
  - LUT3 uses {w[b+5][0], w[b+4]}.
  - The switch box uses w[b+6][15:0].
- Holds the fabric disabled until a complete, checksum-verified image is loaded.

Parameters:
- NUM_WORDS, 56, number of 32-bit configuration words per image.
- SYNC_WORD, 32'hA5C3_0F1E, preamble marking the start of an image.
- WORD_W, 32, configuration word width (fixed; other values unsupported).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- cfg_si  input  1  serial configuration data, MSB-first per word.
- cfg_en  input  1  bit-valid qualifier; cfg_si is sampled only on edges where cfg_en=1.
- cfg_restart  input  1  synchronous pulse; abandon or clear the current image and return to HUNT.
- cfg_words  output  NUM_WORDS*32  flattened word array; word i occupies [32i+31:32i].
- cfg_done  output  1  image loaded and checksum matched.
- cfg_error  output  1  checksum mismatch.
- fabric_en  output  1  fabric enable; equals cfg_done.
- cfg_busy  output  1  high in LOAD or CHECK.

Behaviour:
- Reset (reset_n=0, asynchronous): state=HUNT, shift register=0, bit counter=0, word index=0, checksum accumulator=0, cfg_words=all 0, cfg_done=0, cfg_error=0, fabric_en=0, cfg_busy=0.
- Shift register: 32-bit. On every edge with cfg_en=1, sr <= {sr[30:0], cfg_si}. Nothing changes on edges with cfg_en=0, including the bit counter; gaps of any length are legal.
- HUNT:
  - Sliding-window compare. Go to LOAD on the edge where {sr[30:0], cfg_si} == SYNC_WORD with cfg_en=1.
  - On entry to LOAD: bit counter=0, word index=0, accumulator=0, cfg_done=0, cfg_error=0.
  - cfg_words is not cleared on entry.
- LOAD:
  - The bit counter counts 0..31.
  - On the 32nd qualified bit, word {sr[30:0], cfg_si} is written to cfg_words[index] and added to the accumulator (mod 2^32). The index increments and the bit counter wraps to 0.
  - After word NUM_WORDS−1 is written, go to CHECK.
  - Latency: a word is visible on cfg_words one cycle after the edge that samples its last bit.
- CHECK:
  - Receives one more 32-bit word, the checksum.
  - On its 32nd bit: if it equals the accumulator, go to DONE and set cfg_done=1. Otherwise go to ERROR and set cfg_error=1.
  - Both flags are registered and assert the cycle after that edge.
- DONE: cfg_done=fabric_en=1. Further cfg_si/cfg_en activity is ignored; no re-sync is attempted.
- ERROR: cfg_error=1, fabric_en=0. cfg_words retains the partial or bad image. Further bitstream is ignored.
- cfg_busy is 1 in LOAD and CHECK only.
- cfg_restart=1 (any state, synchronous):
  - Next state HUNT; cfg_done, cfg_error and fabric_en clear; sr=0; counters clear.
  - cfg_words is retained.
  - cfg_restart takes priority over a simultaneous cfg_en bit, which is discarded.
- A sync pattern appearing inside LOAD or CHECK data is treated as data and has no effect.
- Reset asserted mid-LOAD: immediate return to the reset values; the partial image is lost.
- Bits presented in HUNT that precede the sync word are discarded; overlapping partial matches are handled by the sliding window.

Test Plan:
- Nominal load: reset, stream SYNC, then words i → 32'h1000_0000+i for i=0..55, then checksum 32'h0000_0000+Σ mod 2^32. Required: cfg_done=1 and fabric_en=1 one cycle after the last bit; word 55 reads 32'h1000_0037; cfg_error=0.
- Bad checksum: same image, checksum XOR 1. Required: cfg_error=1, cfg_done=0, fabric_en=0; cfg_words holds all 56 data words.
- Gapped stream plus garbage preamble: send 13 random bits, then SYNC with cfg_en toggling 1/0 every cycle. Required: the same final cfg_words and cfg_done as the nominal case.
- Restart and reset mid-load:
  - Assert cfg_restart after 10 words. Required: cfg_busy=0 and state back in HUNT; a fresh full image then loads correctly.
  - Separately, pulse reset_n low mid-word asynchronously. Required: cfg_words=0 and all flags 0 immediately.
- Post-DONE immunity: after DONE, stream a second SYNC plus different data. Required: cfg_words unchanged and cfg_done stays 1 until cfg_restart; restart then reloads the new image.
- Fabric decode check: load an image whose tile-7 words place LUT1 mem = 33'h1_DEAD_BEEF and switch-box configure = 16'h5A5A. Required: the corresponding cfg_words slices match exactly.
